// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Command-level controller wrapped around a combinational ALU. A command
//   (op, a, b, flag, rep) is accepted in IDLE. The ALU is then driven for
//   one or more cycles, with the result fed back as operand A. The final
//   result is returned on a valid/ready response channel.
//
//   INC/DEC/LSH/RSH repeat rep+1 times. For shifts, the ALU flag output is
//   chained into the next iteration's flag input. An illegal op code
//   produces an error response one edge after accept.
//
// Optional feature macro: ALU_SEQ_PERF_EN
//   When defined, adds perf_ops[15:0], a saturating count of completed
//   response handshakes. Error responses are included in the count.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready     command handshake; ready only in IDLE
//   cmd_op/a/b/flag/rep command fields
//   alu_a/b/flagin/ctrl drive the ALU; all zero outside EXEC
//   alu_result/flags    ALU outputs
//   rsp_valid/ready     response handshake
//   rsp_result/flag/err response fields; all zero outside DONE
//   perf_ops            (ALU_SEQ_PERF_EN only) handshake counter
module alu_op_sequencer #(
  parameter int ancho = 4,
  parameter int REP_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [ancho-1:0] cmd_a,
  input  logic [ancho-1:0] cmd_b,
  input  logic             cmd_flag,
  input  logic [REP_W-1:0] cmd_rep,
  output logic [ancho-1:0] alu_a,
  output logic [ancho-1:0] alu_b,
  output logic             alu_flagin,
  output logic [3:0]       alu_ctrl,
  input  logic [ancho-1:0] alu_result,
  input  logic             alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ancho-1:0] rsp_result,
  output logic             rsp_flag,
  output logic             rsp_err
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]      perf_ops
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [3:0]       op_reg;
  logic [ancho-1:0] acc_reg;
  logic [ancho-1:0] b_reg;
  logic             fl_reg;
  logic [REP_W-1:0] iter_reg;
  logic             err_reg;

  // Per-opcode decode tables: legal ops, and ops that honour cmd_rep.
  logic [15:0] legal_mask;
  logic [15:0] rep_mask;
  logic [15:0] shift_mask;

  for (genvar gi = 0; gi < 16; gi++) begin : g_op_decode
    assign legal_mask[gi] = (gi == 0) || (gi == 1) || (gi == 3) || (gi == 4) ||
                            (gi == 5) || (gi == 7) || (gi == 8) || (gi == 9);
    assign rep_mask[gi]   = (gi == 3) || (gi == 4) || (gi == 8) || (gi == 9);
    assign shift_mask[gi] = (gi == 8) || (gi == 9);
  end

  logic in_idle, in_exec, in_done;
  logic op_is_shift;

  assign in_idle     = (state_reg == IDLE);
  assign in_exec     = (state_reg == EXEC);
  assign in_done     = (state_reg == DONE);
  assign op_is_shift = shift_mask[op_reg];

  assign cmd_ready  = in_idle;
  assign alu_ctrl   = in_exec ? op_reg  : 4'h0;
  assign alu_a      = in_exec ? acc_reg : '0;
  assign alu_b      = in_exec ? b_reg   : '0;
  assign alu_flagin = in_exec & fl_reg;

  assign rsp_valid  = in_done;
  assign rsp_result = in_done ? acc_reg : '0;
  // fl_reg still holds the command's flag for non-shift ops, so mask it here.
  assign rsp_flag   = in_done & op_is_shift & fl_reg;
  assign rsp_err    = in_done & err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      op_reg    <= 4'h0;
      acc_reg   <= '0;
      b_reg     <= '0;
      fl_reg    <= 1'b0;
      iter_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            op_reg <= cmd_op;
            b_reg  <= cmd_b;
            if (legal_mask[cmd_op]) begin
              acc_reg   <= cmd_a;
              fl_reg    <= cmd_flag;
              iter_reg  <= rep_mask[cmd_op] ? cmd_rep : '0;
              err_reg   <= 1'b0;
              state_reg <= EXEC;
            end else begin
              // Error response carries a zero result and zero flag.
              acc_reg   <= '0;
              fl_reg    <= 1'b0;
              iter_reg  <= '0;
              err_reg   <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        EXEC: begin
          acc_reg <= alu_result;
          if (op_is_shift) begin
            fl_reg <= alu_flags;
          end
          if (iter_reg == '0) begin
            state_reg <= DONE;
          end else begin
            iter_reg <= iter_reg - 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_reg <= 16'h0000;
    end else if (in_done && rsp_ready && (perf_reg != 16'hFFFF)) begin
      perf_reg <= perf_reg + 16'h0001;
    end
  end

  assign perf_ops = perf_reg;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: a behavioural ALU model, directed cases,
// and random commands checked against a reference model.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = 4'h0;
  logic [3:0] cmd_a = 4'h0;
  logic [3:0] cmd_b = 4'h0;
  logic       cmd_flag = 1'b0;
  logic [2:0] cmd_rep = 3'd0;
  logic [3:0] alu_a, alu_b, alu_ctrl;
  logic       alu_flagin;
  logic [3:0] alu_result;
  logic       alu_flags;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_result;
  logic       rsp_flag, rsp_err;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perf_ops;
`endif

  int total = 0;
  int bad   = 0;
  int n_hs  = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.ancho(4), .REP_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_flag(cmd_flag), .cmd_rep(cmd_rep),
    .alu_a(alu_a), .alu_b(alu_b), .alu_flagin(alu_flagin), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flag(rsp_flag), .rsp_err(rsp_err)
`ifdef ALU_SEQ_PERF_EN
    , .perf_ops(perf_ops)
`endif
  );

  // Behavioural ALU: returns {flag, result}.
  function automatic logic [4:0] alu_f(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic fi);
    case (op)
      4'h0: alu_f = {1'b0, a & b};
      4'h1: alu_f = {1'b0, a | b};
      4'h3: alu_f = {1'b0, 4'(a + 4'd1)};
      4'h4: alu_f = {1'b0, 4'(a - 4'd1)};
      4'h5: alu_f = {1'b0, 4'(-a)};
      4'h7: alu_f = {1'b0, a ^ b};
      4'h8: alu_f = {a[3], a[2:0], fi};
      4'h9: alu_f = {a[0], fi, a[3:1]};
      default: alu_f = 5'h00;
    endcase
  endfunction

  always_comb begin
    {alu_flags, alu_result} = alu_f(alu_ctrl, alu_a, alu_b, alu_flagin);
  end

  function automatic bit is_legal(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9};
  endfunction

  function automatic bit is_rep(input logic [3:0] op);
    return op inside {4'h3, 4'h4, 4'h8, 4'h9};
  endfunction

  // Reference: returns {latency[7:0], err, flag, result[3:0]}.
  function automatic logic [13:0] ref_run(input logic [3:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input logic f,
                                          input logic [2:0] rep);
    logic [3:0] acc;
    logic       fl;
    logic [4:0] r;
    int         n;
    if (!is_legal(op)) return {8'd1, 1'b1, 1'b0, 4'h0};
    n   = is_rep(op) ? int'(rep) + 1 : 1;
    acc = a;
    fl  = f;
    for (int i = 0; i < n; i++) begin
      r   = alu_f(op, acc, b, fl);
      acc = r[3:0];
      if (op == 4'h8 || op == 4'h9) fl = r[4];
    end
    if (!(op == 4'h8 || op == 4'h9)) fl = 1'b0;
    return {8'(n), 1'b0, fl, acc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one command through to its handshake, holding rsp_ready low
  // for 'hold' cycles once the response is presented.
  task automatic run_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic f, input logic [2:0] rep, input int hold);
    logic [13:0] exp;
    int          lat;
    exp = ref_run(op, a, b, f, rep);
    chk("ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_flag = f; cmd_rep = rep;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (1) begin
      if (lat > 0 && rsp_valid) break;
      if (lat > 20) break;
      if (lat > 0) chk("ready_low_busy", cmd_ready, 1'b0);
      if (lat > 0 && is_legal(op)) chk("alu_ctrl_exec", alu_ctrl, op);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp[13:6]);
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_result", rsp_result, exp[3:0]);
      chk("rsp_flag", rsp_flag, exp[4]);
      chk("rsp_err", rsp_err, exp[5]);
      chk("ready_low_done", cmd_ready, 1'b0);
      chk("alu_ctrl_done", alu_ctrl, 4'h0);
      if (h < hold) begin @(posedge clk); #1; end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_hs++;
    chk("idle_after_hs", cmd_ready, 1'b1);
    chk("rsp_valid_after_hs", rsp_valid, 1'b0);
    $display("txn op=%0h a=%0h b=%0h f=%0b rep=%0d hold=%0d -> res=%0h flag=%0b err=%0b lat=%0d",
             op, a, b, f, rep, hold, exp[3:0], exp[4], exp[5], lat);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_alu_ctrl", alu_ctrl, 4'h0);
    chk("rst_alu_a", alu_a, 4'h0);
    chk("rst_rsp_result", rsp_result, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_cmd(4'h0, 4'hC, 4'hA, 1'b0, 3'd5, 0);
    run_cmd(4'h3, 4'hE, 4'h0, 1'b0, 3'd2, 0);
    run_cmd(4'h8, 4'b1001, 4'h0, 1'b0, 3'd1, 0);
    run_cmd(4'h6, 4'h7, 4'h3, 1'b1, 3'd4, 0);
    run_cmd(4'h4, 4'h1, 4'h0, 1'b1, 3'd3, 5);
    run_cmd(4'h9, 4'h6, 4'h0, 1'b1, 3'd7, 1);
    run_cmd(4'h5, 4'h3, 4'h0, 1'b1, 3'd0, 0);

    // Back-to-back: cmd_valid held across DONE must not be taken early.
    cmd_valid = 1'b1; cmd_op = 4'h1; cmd_a = 4'h5; cmd_b = 4'hA; cmd_rep = 3'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_done_valid", rsp_valid, 1'b1);
    chk("b2b_result", rsp_result, 4'hF);
    @(posedge clk); #1;
    chk("b2b_still_done", rsp_valid, 1'b1);
    chk("b2b_no_accept", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_hs++;
    chk("b2b_idle", cmd_ready, 1'b1);
    $display("txn b2b op=1 a=5 b=a -> res=f");

    // Reset mid-EXEC of op 9 rep 7
    cmd_valid = 1'b1; cmd_op = 4'h9; cmd_a = 4'hB; cmd_rep = 3'd7; cmd_flag = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_exec", alu_ctrl, 4'h9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", cmd_ready, 1'b1);
    chk("mid_rst_alu_ctrl", alu_ctrl, 4'h0);
    chk("mid_rst_alu_a", alu_a, 4'h0);
    chk("mid_rst_flagin", alu_flagin, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("no_rsp_after_rst", rsp_valid, 1'b0);
    end
    $display("txn reset-abort op=9 rep=7");
    n_hs = 0;

    // Random commands
    for (int t = 0; t < 40; t++) begin
      run_cmd(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 1'($urandom),
              3'($urandom), int'($urandom_range(0, 2)));
    end

`ifdef ALU_SEQ_PERF_EN
    chk("perf_ops", perf_ops, n_hs);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
